// File: rtl/bip_sequencer.sv
// rtl/bip_sequencer.sv - program loader and run/step controller for a BIP CPU
//
// Purpose: streams a program into instruction memory, then runs it freely or
// one instruction at a time, watching the fetched opcode for HALT (opcode 0).
//
// Ports:
//   clk, reset          clock; asynchronous active-low reset
//   cmd_valid/code/ready command channel (00 LOAD, 01 RUN, 10 STEP, 11 ABORT)
//   ld_valid/data/last/ready  program word stream
//   prog_we/addr/wdata  program memory write port
//   fetch_opcode        opcode at the CPU's current PC
//   cpu_start, cpu_clr  CPU PC-enable and synchronous clear
//   busy, done, halted, load_err, cycle_count  status
module bip_sequencer #(
  parameter int len_data   = 16,
  parameter int len_addr   = 11,
  parameter int len_opcode = 5,
  parameter int len_cnt    = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_valid,
  input  logic [1:0]            cmd_code,
  output logic                  cmd_ready,
  input  logic                  ld_valid,
  input  logic [len_data-1:0]   ld_data,
  input  logic                  ld_last,
  output logic                  ld_ready,
  output logic                  prog_we,
  output logic [len_addr-1:0]   prog_addr,
  output logic [len_data-1:0]   prog_wdata,
  input  logic [len_opcode-1:0] fetch_opcode,
  output logic                  cpu_start,
  output logic                  cpu_clr,
  output logic                  busy,
  output logic                  done,
  output logic                  halted,
  output logic                  load_err,
  output logic [len_cnt-1:0]    cycle_count
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_CLEAR, S_RUN, S_PAUSE, S_STEP
  } state_t;

  localparam logic [1:0] CMD_LOAD  = 2'b00;
  localparam logic [1:0] CMD_RUN   = 2'b01;
  localparam logic [1:0] CMD_STEP  = 2'b10;
  localparam logic [1:0] CMD_ABORT = 2'b11;

  localparam logic [len_addr-1:0] ADDR_MAX = '1;
  localparam logic [len_cnt-1:0]  CNT_MAX  = '1;

  state_t              state_q, state_d;
  logic [len_addr-1:0] addr_q, addr_d;
  logic                step_mode_q, step_mode_d;
  logic [len_cnt-1:0]  cnt_q, cnt_d;
  logic                halted_q, halted_d;
  logic                load_err_q, load_err_d;
  logic                done_q, done_d;

  logic is_halt;
  logic abort_cmd;

  assign is_halt   = (fetch_opcode == '0);
  // Only meaningful in states where cmd_ready is 1.
  assign abort_cmd = cmd_valid && (cmd_code == CMD_ABORT);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      step_mode_q <= 1'b0;
      cnt_q       <= '0;
      halted_q    <= 1'b0;
      load_err_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      step_mode_q <= step_mode_d;
      cnt_q       <= cnt_d;
      halted_q    <= halted_d;
      load_err_q  <= load_err_d;
      done_q      <= done_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    step_mode_d = step_mode_q;
    cnt_d       = cnt_q;
    halted_d    = halted_q;
    load_err_d  = load_err_q;
    done_d      = 1'b0;
    cmd_ready   = 1'b1;
    ld_ready    = 1'b0;
    prog_we     = 1'b0;
    prog_addr   = '0;
    prog_wdata  = '0;
    cpu_start   = 1'b0;
    cpu_clr     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          case (cmd_code)
            CMD_LOAD: begin
              state_d    = S_LOAD;
              addr_d     = '0;
              load_err_d = 1'b0;
            end
            CMD_RUN: begin
              state_d     = S_CLEAR;
              step_mode_d = 1'b0;
            end
            CMD_STEP: begin
              state_d     = S_CLEAR;
              step_mode_d = 1'b1;
            end
            default: ;
          endcase
        end
      end
      S_LOAD: begin
        ld_ready = 1'b1;
        if (abort_cmd) begin
          state_d = S_IDLE;
        end else if (ld_valid) begin
          prog_we    = 1'b1;
          prog_addr  = addr_q;
          prog_wdata = ld_data;
          // Address never wraps: the top slot is written and then either
          // the load ends cleanly (ld_last) or is flagged as an overflow.
          if (addr_q != ADDR_MAX) begin
            addr_d = addr_q + 1'b1;
          end
          if (ld_last) begin
            state_d = S_IDLE;
          end else if (addr_q == ADDR_MAX) begin
            load_err_d = 1'b1;
            state_d    = S_IDLE;
          end
        end
      end
      S_CLEAR: begin
        cmd_ready = 1'b0;
        cpu_clr   = 1'b1;
        cnt_d     = '0;
        halted_d  = 1'b0;
        state_d   = step_mode_q ? S_PAUSE : S_RUN;
      end
      S_RUN: begin
        cpu_start = !is_halt;
        if (abort_cmd) begin
          state_d = S_IDLE;
        end else if (is_halt) begin
          halted_d = 1'b1;
          done_d   = 1'b1;
          state_d  = S_IDLE;
        end
      end
      S_PAUSE: begin
        if (abort_cmd) begin
          state_d = S_IDLE;
        end else if (is_halt) begin
          halted_d = 1'b1;
          done_d   = 1'b1;
          state_d  = S_IDLE;
        end else if (cmd_valid && cmd_code == CMD_STEP) begin
          state_d = S_STEP;
        end else if (cmd_valid && cmd_code == CMD_RUN) begin
          state_d = S_RUN;
        end
      end
      S_STEP: begin
        cmd_ready = 1'b0;
        cpu_start = 1'b1;
        state_d   = S_PAUSE;
      end
      default: state_d = S_IDLE;
    endcase

    if (cpu_start && cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + len_cnt'(1);
    end
  end

  assign busy        = (state_q != S_IDLE);
  assign done        = done_q;
  assign halted      = halted_q;
  assign load_err    = load_err_q;
  assign cycle_count = cnt_q;

endmodule

// File: tb/tb_bip_sequencer.sv
// tb/tb_bip_sequencer.sv - randomized self-checking bench for bip_sequencer
module tb_bip_sequencer;

  localparam int LD = 16;
  localparam int LA = 2;
  localparam int LO = 5;
  localparam int LC = 2;
  localparam int CAP = 1 << LA;
  localparam int CMAX = (1 << LC) - 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          cmd_valid;
  logic [1:0]    cmd_code;
  logic          cmd_ready;
  logic          ld_valid;
  logic [LD-1:0] ld_data;
  logic          ld_last;
  logic          ld_ready;
  logic          prog_we;
  logic [LA-1:0] prog_addr;
  logic [LD-1:0] prog_wdata;
  logic [LO-1:0] fetch_opcode;
  logic          cpu_start;
  logic          cpu_clr;
  logic          busy;
  logic          done;
  logic          halted;
  logic          load_err;
  logic [LC-1:0] cycle_count;

  bip_sequencer #(.len_data(LD), .len_addr(LA), .len_opcode(LO), .len_cnt(LC)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_code(cmd_code), .cmd_ready(cmd_ready),
    .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last), .ld_ready(ld_ready),
    .prog_we(prog_we), .prog_addr(prog_addr), .prog_wdata(prog_wdata),
    .fetch_opcode(fetch_opcode), .cpu_start(cpu_start), .cpu_clr(cpu_clr),
    .busy(busy), .done(done), .halted(halted), .load_err(load_err),
    .cycle_count(cycle_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // CPU environment: a PC walking a program of opcodes.
  logic [LO-1:0] prog_ops [0:31];
  int            pc = 0;
  logic          c_start = 1'b0;
  logic          c_clr = 1'b0;
  assign fetch_opcode = prog_ops[pc[4:0]];

  // Monotonic event counters, sampled mid-cycle.
  int            n_we = 0, n_start = 0, n_clr = 0, n_done = 0;
  logic [LA-1:0] wr_addr [0:63];
  logic [LD-1:0] wr_data [0:63];

  always @(negedge clk) begin
    c_start <= cpu_start;
    c_clr   <= cpu_clr;
    if (cpu_start) n_start <= n_start + 1;
    if (cpu_clr)   n_clr   <= n_clr + 1;
    if (done)      n_done  <= n_done + 1;
    if (prog_we) begin
      wr_addr[n_we[5:0]] <= prog_addr;
      wr_data[n_we[5:0]] <= prog_wdata;
      n_we <= n_we + 1;
    end
  end

  always @(posedge clk) begin
    if (c_clr) pc <= 0;
    else if (c_start && pc < 31) pc <= pc + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int min_i(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  task automatic send_cmd(input logic [1:0] code);
    int n;
    n = 0;
    cmd_valid = 1'b1;
    cmd_code  = code;
    @(negedge clk);
    while (!cmd_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("cmd_accept", cmd_ready, 1);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  // Load n random words; ld_last on the final word when with_last is set.
  task automatic do_load(input int n, input bit with_last, input bit run_cmd_too);
    logic [LD-1:0] words [0:7];
    int  b, i, exp_w;
    bit  exp_err, still_loading, broke;
    for (int j = 0; j < 8; j++) words[j] = LD'($urandom);
    exp_w         = min_i(n, CAP);
    exp_err       = (n > CAP);
    still_loading = !with_last && (n <= CAP);
    b = n_we;
    send_cmd(2'b00);
    i = 0;
    broke = 1'b0;
    while (i < n && !broke) begin
      ld_valid  = 1'b1;
      ld_data   = words[i];
      ld_last   = with_last && (i == n - 1);
      cmd_valid = run_cmd_too && (i == 0);
      cmd_code  = 2'b01;
      @(negedge clk);
      if (!ld_ready) begin
        broke = 1'b1;
      end else begin
        @(posedge clk);
        #1;
        i++;
      end
    end
    ld_valid  = 1'b0;
    ld_last   = 1'b0;
    cmd_valid = 1'b0;
    if (broke) tick();
    if (still_loading) begin
      chk("load_busy_open", busy, 1);
      ld_valid = 1'b1;
      ld_data  = LD'($urandom);
      send_cmd(2'b11);
      ld_valid = 1'b0;
    end
    tick();
    chk("load_nwrites", n_we - b, exp_w);
    for (int j = 0; j < exp_w; j++) begin
      chk("load_addr", wr_addr[(b + j) % 64], j);
      chk("load_data", wr_data[(b + j) % 64], words[j]);
    end
    chk("load_err", load_err, exp_err);
    chk("load_busy_end", busy, 0);
    chk("load_ready_end", ld_ready, 0);
  endtask

  // Program of k nonzero opcodes then HALT; step mode issues s STEPs then RUN.
  task automatic do_run(input int k, input bit step_mode, input int s);
    int bs, bc, bd, n;
    for (int j = 0; j < 32; j++) prog_ops[j] = (j < k) ? LO'($urandom_range(1, 31)) : '0;
    bs = n_start; bc = n_clr; bd = n_done;
    if (!step_mode) begin
      send_cmd(2'b01);
    end else begin
      send_cmd(2'b10);
      tick();
      chk("pause_no_start", cpu_start, 0);
      for (int j = 1; j <= s; j++) begin
        send_cmd(2'b10);
        @(negedge clk);
        chk("step_start", cpu_start, 1);
        chk("step_cmd_ready", cmd_ready, 0);
        tick();
        chk("step_count", cycle_count, min_i(j, CMAX));
      end
      if (s < k) send_cmd(2'b01);
    end
    n = 0;
    while (busy && n < 200) begin
      tick();
      n++;
    end
    chk("halt_timeout", busy, 0);
    repeat (2) tick();
    chk("run_starts", n_start - bs, k);
    chk("run_clears", n_clr - bc, 1);
    chk("run_done", n_done - bd, 1);
    chk("run_halted", halted, 1);
    chk("run_count", cycle_count, min_i(k, CMAX));
  endtask

  task automatic do_abort_at_halt();
    int bs, bc, bd;
    for (int j = 0; j < 32; j++) prog_ops[j] = '0;
    bs = n_start; bc = n_clr; bd = n_done;
    send_cmd(2'b01);
    send_cmd(2'b11);
    repeat (2) tick();
    chk("abort_done", n_done - bd, 0);
    chk("abort_halted", halted, 0);
    chk("abort_busy", busy, 0);
    chk("abort_starts", n_start - bs, 0);
    chk("abort_clears", n_clr - bc, 1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_cmd_ready"}, cmd_ready, 1);
    chk({tag, "_ld_ready"}, ld_ready, 0);
    chk({tag, "_prog_we"}, prog_we, 0);
    chk({tag, "_prog_addr"}, prog_addr, 0);
    chk({tag, "_prog_wdata"}, prog_wdata, 0);
    chk({tag, "_cpu_start"}, cpu_start, 0);
    chk({tag, "_cpu_clr"}, cpu_clr, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_halted"}, halted, 0);
    chk({tag, "_load_err"}, load_err, 0);
    chk({tag, "_count"}, cycle_count, 0);
  endtask

  initial begin
    int r, k, bs, bw;
    reset = 1'b0; cmd_valid = 1'b0; cmd_code = 2'b00;
    ld_valid = 1'b0; ld_data = '0; ld_last = 1'b0;
    for (int j = 0; j < 32; j++) prog_ops[j] = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("rst");
    reset = 1'b1;
    tick();

    do_load(3, 1'b1, 1'b0);
    do_load(5, 1'b0, 1'b0);
    do_load(2, 1'b0, 1'b1);
    do_load(4, 1'b1, 1'b0);
    do_run(3, 1'b0, 0);
    do_run(3, 1'b1, 2);
    do_abort_at_halt();
    do_run(6, 1'b0, 0);
    do_run(0, 1'b0, 0);

    for (int it = 0; it < 12; it++) begin
      r = $urandom_range(0, 2);
      if (r == 0) begin
        do_load($urandom_range(1, 6), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end else if (r == 1) begin
        do_run($urandom_range(0, 7), 1'b0, 0);
      end else begin
        k = $urandom_range(1, 5);
        do_run(k, 1'b1, $urandom_range(1, k));
      end
    end

    // Reset in the middle of a long free run.
    for (int j = 0; j < 32; j++) prog_ops[j] = (j < 12) ? 5'd7 : 5'd0;
    send_cmd(2'b01);
    repeat (4) tick();
    reset = 1'b0;
    #1;
    chk_reset_outputs("rst_run");
    bs = n_start;
    repeat (3) tick();
    chk("rst_run_no_start", n_start - bs, 0);
    reset = 1'b1;
    tick();

    // Reset in the middle of a load with a word still offered.
    send_cmd(2'b00);
    ld_valid = 1'b1;
    ld_data  = 16'h5a5a;
    tick();
    reset = 1'b0;
    #1;
    chk_reset_outputs("rst_load");
    bw = n_we;
    repeat (3) tick();
    chk("rst_load_no_we", n_we - bw, 0);
    ld_valid = 1'b0;
    reset = 1'b1;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
